// File: rtl/ucie_ctl_sb_tx_serializer.sv
// Sideband TX serializer: buffers one header/data packet and shifts 32-bit phases out on an NC-bit lane.
// Optional build macro UCIE_CTL_SB_TX_PARITY_EN inserts CP/DP parity into header bits 62/63 on capture.
module ucie_ctl_sb_tx_serializer #(
    parameter int NC = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [63:0]   i_header,
    input  logic [63:0]   i_data,
    input  logic [1:0]    i_buf_en,
    input  logic [1:0]    i_shift_load,
    input  logic [1:0]    i_phase_sel,
    output logic [NC-1:0] o_sb_tx_data,
    output logic          o_sb_tx_vld,
    output logic          o_done_shift
);

    localparam int         BEATS      = 32 / NC;
    localparam logic [2:0] BEATS_INIT = 3'(BEATS);

    logic [63:0] hdr_q,   hdr_d;
    logic [63:0] data_q,  data_d;
    logic [31:0] sreg_q,  sreg_d;
    logic [2:0]  beats_q, beats_d;
    logic        done_q,  done_d;
    logic [31:0] phase_word;

    // Loads always read the registered buffers, so a same-edge capture is not seen yet.
    always_comb begin
        phase_word = hdr_q[31:0];
        case (i_phase_sel)
            2'd0:    phase_word = hdr_q[31:0];
            2'd1:    phase_word = hdr_q[63:32];
            2'd2:    phase_word = data_q[31:0];
            default: phase_word = data_q[63:32];
        endcase
    end

    always_comb begin
        hdr_d   = hdr_q;
        data_d  = data_q;
        sreg_d  = sreg_q;
        beats_d = beats_q;
        done_d  = 1'b0;

        if (i_buf_en[0]) begin
`ifdef UCIE_CTL_SB_TX_PARITY_EN
            hdr_d[61:0] = i_header[61:0];
            hdr_d[62]   = ^i_header[61:0];
`else
            hdr_d = i_header;
`endif
        end
        if (i_buf_en[1]) begin
            data_d = i_data;
`ifdef UCIE_CTL_SB_TX_PARITY_EN
            hdr_d[63] = ^i_data;
`endif
        end

        case (i_shift_load)
            2'b01: begin
                sreg_d  = phase_word;
                beats_d = BEATS_INIT;
                done_d  = (BEATS_INIT == 3'd1);
            end
            2'b10: begin
                // The last beat stays on the lane data bits; only the counter drops to zero.
                if (beats_q > 3'd1) begin
                    sreg_d  = sreg_q >> NC;
                    beats_d = beats_q - 3'd1;
                    done_d  = (beats_q == 3'd2);
                end else if (beats_q == 3'd1) begin
                    beats_d = 3'd0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hdr_q   <= '0;
            data_q  <= '0;
            sreg_q  <= '0;
            beats_q <= '0;
            done_q  <= 1'b0;
        end else begin
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            sreg_q  <= sreg_d;
            beats_q <= beats_d;
            done_q  <= done_d;
        end
    end

    assign o_sb_tx_data = sreg_q[NC-1:0];
    assign o_sb_tx_vld  = (beats_q != 3'd0);
    assign o_done_shift = done_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_serializer.sv
// Directed bench: three lane widths (8/16/32) driven from one shared command stream.
module tb_ucie_ctl_sb_tx_serializer;

    logic        clk;
    logic        i_rst;
    logic [63:0] i_header;
    logic [63:0] i_data;
    logic [1:0]  i_buf_en;
    logic [1:0]  i_shift_load;
    logic [1:0]  i_phase_sel;

    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;
    logic        v8, v16, v32;
    logic        dn8, dn16, dn32;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp8  [0:15];
    logic [31:0] exp32 [0:3];
    logic [31:0] par_exp;

    ucie_ctl_sb_tx_serializer #(.NC(8)) u8 (
        .i_clk(clk), .i_rst(i_rst), .i_header(i_header), .i_data(i_data),
        .i_buf_en(i_buf_en), .i_shift_load(i_shift_load), .i_phase_sel(i_phase_sel),
        .o_sb_tx_data(d8), .o_sb_tx_vld(v8), .o_done_shift(dn8)
    );
    ucie_ctl_sb_tx_serializer #(.NC(16)) u16 (
        .i_clk(clk), .i_rst(i_rst), .i_header(i_header), .i_data(i_data),
        .i_buf_en(i_buf_en), .i_shift_load(i_shift_load), .i_phase_sel(i_phase_sel),
        .o_sb_tx_data(d16), .o_sb_tx_vld(v16), .o_done_shift(dn16)
    );
    ucie_ctl_sb_tx_serializer #(.NC(32)) u32 (
        .i_clk(clk), .i_rst(i_rst), .i_header(i_header), .i_data(i_data),
        .i_buf_en(i_buf_en), .i_shift_load(i_shift_load), .i_phase_sel(i_phase_sel),
        .o_sb_tx_data(d32), .o_sb_tx_vld(v32), .o_done_shift(dn32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] sl, input logic [1:0] ph);
        i_shift_load = sl;
        i_phase_sel  = ph;
        tick();
    endtask

    initial begin
        exp8 = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
                 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        exp32 = '{32'h89AB_CDEF, 32'h0123_4567, 32'h7654_3210, 32'hFEDC_BA98};
`ifdef UCIE_CTL_SB_TX_PARITY_EN
        par_exp = 32'h4000_0000;
`else
        par_exp = 32'h0000_0000;
`endif

        // Reset state
        i_rst = 1'b0; i_header = '0; i_data = '0;
        i_buf_en = 2'b00; i_shift_load = 2'b00; i_phase_sel = 2'd0;
        tick(); tick();
        check("rst_vld8", 32'(v8), 32'h0);
        check("rst_data8", 32'(d8), 32'h0);
        check("rst_done8", 32'(dn8), 32'h0);

        // Release and capture both buffers
        i_rst = 1'b1;
        i_header = 64'h0123_4567_89AB_CDEF;
        i_data   = 64'hFEDC_BA98_7654_3210;
        i_buf_en = 2'b11;
        tick();
        i_buf_en = 2'b00;
        check("cap_vld8", 32'(v8), 32'h0);
        check("cap_done8", 32'(dn8), 32'h0);

        // NC=8 full packet, gapless; NC=16 observed on phase 0
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                cmd((b == 0) ? 2'b01 : 2'b10, 2'(p));
                check($sformatf("pkt8_data_%0d", p*4+b), 32'(d8), 32'(exp8[p*4+b]));
                check($sformatf("pkt8_vld_%0d", p*4+b), 32'(v8), 32'h1);
                check($sformatf("pkt8_done_%0d", p*4+b), 32'(dn8), (b == 3) ? 32'h1 : 32'h0);
                if (p == 0 && b == 0) begin
                    check("n16_b0", 32'(d16), 32'(exp32[0][15:0]));
                    check("n16_done_b0", 32'(dn16), 32'h0);
                end
                if (p == 0 && b == 1) begin
                    check("n16_b1", 32'(d16), 32'(exp32[0][31:16]));
                    check("n16_done_b1", 32'(dn16), 32'h1);
                end
                if (p == 0 && b == 2) check("n16_vld_end", 32'(v16), 32'h0);
            end
        end
        cmd(2'b10, 2'd0);
        check("end8_vld", 32'(v8), 32'h0);
        check("end8_done", 32'(dn8), 32'h0);
        cmd(2'b10, 2'd0);
        check("idle_shift_vld", 32'(v8), 32'h0);

        // NC=32 loads on consecutive edges
        for (int p = 0; p < 4; p++) begin
            cmd(2'b01, 2'(p));
            check($sformatf("n32_data_%0d", p), d32, exp32[p]);
            check($sformatf("n32_done_%0d", p), 32'(dn32), 32'h1);
            check($sformatf("n32_vld_%0d", p), 32'(v32), 32'h1);
        end
        cmd(2'b00, 2'd0);
        check("n32_hold_done", 32'(dn32), 32'h0);

        // Illegal command holds, abort mid-phase, hold on last beat
        cmd(2'b01, 2'd0);
        cmd(2'b10, 2'd0);
        cmd(2'b11, 2'd0);
        check("cmd11_data", 32'(d8), 32'hCD);
        check("cmd11_vld", 32'(v8), 32'h1);
        cmd(2'b10, 2'd0);
        check("abort_pre", 32'(d8), 32'hAB);
        cmd(2'b01, 2'd1);
        check("abort_data", 32'(d8), 32'h67);
        check("abort_done", 32'(dn8), 32'h0);
        cmd(2'b10, 2'd1);
        cmd(2'b10, 2'd1);
        check("abort_done_b2", 32'(dn8), 32'h0);
        cmd(2'b10, 2'd1);
        check("last_done", 32'(dn8), 32'h1);
        cmd(2'b00, 2'd1);
        check("hold1_done", 32'(dn8), 32'h0);
        check("hold1_data", 32'(d8), 32'h01);
        cmd(2'b00, 2'd1);
        check("hold2_done", 32'(dn8), 32'h0);
        cmd(2'b11, 2'd1);
        check("hold3_done", 32'(dn8), 32'h0);
        check("hold3_vld", 32'(v8), 32'h1);

        // Same-edge capture and load uses the old data buffer
        i_data = 64'h5; i_buf_en = 2'b10;
        cmd(2'b00, 2'd0);
        i_data = 64'h1;
        cmd(2'b01, 2'd2);
        i_buf_en = 2'b00;
        check("same_edge8", 32'(d8), 32'h05);
        check("same_edge32", d32, 32'h5);
        cmd(2'b01, 2'd2);
        check("next_load8", 32'(d8), 32'h01);

        // Asynchronous reset in the middle of a phase
        cmd(2'b01, 2'd2);
        cmd(2'b10, 2'd2);
        #2;
        i_rst = 1'b0;
        #1;
        check("async_vld", 32'(v8), 32'h0);
        check("async_data", 32'(d8), 32'h0);
        check("async_done", 32'(dn8), 32'h0);
        i_shift_load = 2'b00;
        tick();
        i_rst = 1'b1;
        cmd(2'b10, 2'd0);
        cmd(2'b00, 2'd0);
        check("post_rst_vld", 32'(v8), 32'h0);
        check("post_rst_done", 32'(dn8), 32'h0);
        check("post_rst_done32", 32'(dn32), 32'h0);
        cmd(2'b01, 2'd0);
        check("post_rst_buf", d32, 32'h0);
        check("post_rst_vld32", 32'(v32), 32'h1);

        // Parity insertion into header bits 62/63
        i_header = 64'h7; i_data = 64'h3; i_buf_en = 2'b11;
        cmd(2'b00, 2'd0);
        i_buf_en = 2'b00;
        cmd(2'b01, 2'd1);
        check("parity_word", d32, par_exp);
        check("parity_byte8", 32'(d8), 32'h00);
        cmd(2'b01, 2'd0);
        check("parity_low", d32, 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_sb_tx_serializer.md
# ucie_ctl_sb_tx_serializer

Sideband TX datapath stage that sits directly downstream of the sideband TX control FSM. It captures the 64-bit header and 64-bit data of one sideband packet, then slices the packet into four 32-bit phases. Each phase is serialized onto an NC-bit lane toward the sideband PHY under the FSM's buffer/load/shift/phase commands. It returns a one-cycle done pulse to the FSM at the last beat of every phase.

## Interface
- NC, 8, lane width in bits; legal values 8, 16, 32
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  asynchronous active-low reset
- i_header  input  64  packet header from the CTL interface
- i_data  input  64  packet data payload from the CTL interface
- i_buf_en  input  2  bit0: capture i_header; bit1: capture i_data
- i_shift_load  input  2  01 load phase, 10 shift, 00 hold, 11 hold (illegal)
- i_phase_sel  input  2  phase for a load: 0 hdr[31:0], 1 hdr[63:32], 2 data[31:0], 3 data[63:32]
- o_sb_tx_data  output  NC  current lane beat, LSB-first slice of the shift register
- o_sb_tx_vld  output  1  lane beat valid
- o_done_shift  output  1  one-cycle pulse in the cycle the last beat of a phase is first presented

## Operation
- Buffers: r_hdr, r_data (64b each). Capture at the clock edge where the matching i_buf_en bit is 1. Both bits may be set together. A capture never disturbs the shift register contents.
- Shift register: r_sreg (32b). Beat counter: r_beats (0..32/NC, 3b).
- Load (01): r_sreg <= selected 32b word from the *registered* buffers; r_beats <= 32/NC. A load overrides any phase in progress; the remaining beats of that phase are dropped.
- Shift (10) with r_beats > 1: r_sreg >>= NC, r_beats -= 1.
- Shift with r_beats == 1: r_beats <= 0, r_sreg unchanged.
- Shift with r_beats == 0: ignored.
- Hold (00/11): no change.
- o_sb_tx_data = r_sreg[NC-1:0]; o_sb_tx_vld = (r_beats != 0).
- o_done_shift: registered. Set on any edge where r_beats becomes 1, either by a load when NC=32 or by a shift from 2. Cleared otherwise. It is therefore high for exactly one cycle per phase, even if the FSM holds.
- Same-edge capture and load: the load uses the *old* buffer contents. The FSM must capture at least one cycle before loading.
- No internal FSM beyond the beat counter. Sequencing is owned by the upstream FSM.

## Timing
- Reset (i_rst low, async): r_hdr, r_data, r_sreg = 0; r_beats = 0; o_sb_tx_data = 0, o_sb_tx_vld = 0, o_done_shift = 0.
- Release is sampled synchronously; the first command is accepted on the first rising edge with i_rst high.
- Load at edge N: beat 0 on the lane and vld=1 in cycle N+1.
- NC=8, load at N with shifts at N+1..N+3: beats 0..3 in cycles N+1..N+4; o_done_shift=1 in cycle N+4; shift at N+4 makes vld=0 in N+5.
- NC=16: done in the cycle after the first shift.
- NC=32: done and vld in cycle N+1 directly after a load.
- Back-to-back phases: a load on the edge that consumes the last beat gives a gapless lane.
- Reset asserted mid-phase: outputs clear immediately (asynchronous). No partial beat or done pulse is emitted after release.

## Configuration
- UCIE_CTL_SB_TX_PARITY_EN defined:
  - On a header capture, r_hdr[62] <= ^i_header[61:0] (CP).
  - On a data capture, r_hdr[63] <= ^i_data (DP).
  - The CP and DP inputs are overwritten. With a simultaneous capture, both are computed from the incoming words.
  - DP is also updated on a data-only capture, while r_hdr[61:0] is kept.
- Not defined: r_hdr is a verbatim copy of i_header. No parity logic is synthesized.

## Test plan
- Reset value check:
  - Assert i_rst low mid-phase (NC=8, r_beats=3) -> o_sb_tx_vld=0, o_sb_tx_data=0, o_done_shift=0 in the same cycle.
  - After release, no done pulse without a load.
- NC=8 full packet:
  - Stimulus: i_header=64'h0123_4567_89AB_CDEF, i_data=64'hFEDC_BA98_7654_3210; capture 11; phases 0..3, each loaded then shifted 3 times.
  - Expected lane: EF,CD,AB,89,67,45,23,01,10,32,54,76,98,BA,DC,FE, contiguous.
  - Expected o_done_shift: exactly 4 one-cycle pulses, one on each 4th beat.
- NC=32:
  - Stimulus: loads of phases 0..3 on consecutive edges.
  - Expected lane: 89ABCDEF, 01234567, 76543210, FEDCBA98 in 4 consecutive cycles, with o_done_shift high in each.
- Boundary commands:
  - Shift with r_beats=0 -> vld stays 0.
  - i_shift_load=11 -> state held.
  - Load at beat 2 of 4 -> new phase beat 0 next cycle, no done pulse for the aborted phase.
  - Hold at the last beat for 3 cycles -> done high for 1 cycle only.
- Capture/load same edge:
  - Stimulus: capture data 64'h1 while loading phase 2 with old data 64'h5.
  - Expected: lane beat 0 = 8'h05 (NC=8).
  - A next load of phase 2 gives beat 0 = 8'h01.
- Parity (macro on):
  - Stimulus: capture i_header=64'h0000_0000_0000_0007, i_data=64'h3.
  - Expected: phase 1 word = 32'h4000_0000 (CP=1, DP=0).
  - With the macro off, the same stimulus gives 32'h0000_0000.
